cursor_paint_ctrl: RTL and testbench

//  Sequencer/arbiter for the single-port 1-bit cursor bitmap RAM (HSIZE x VSIZE, row-major).

---
 rtl/cursor_paint_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_cursor_paint_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_paint_ctrl.sv
// Cursor bitmap RAM sequencer: display reads win the single RAM port, clear/mark/move writes fill the gaps.
// Build option CURSOR_TRAIL_EN: one write per step, so visited pixels stay lit.
module cursor_paint_ctrl #(
   parameter int HSIZE = 480,
   parameter int VSIZE = 272,
   parameter int STEP  = 5,
   parameter int AW    = 17
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic [2:0]    PushButton,
   input  logic          clr_req,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic          disp_data,
   output logic          disp_valid,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wdata,
   input  logic          mem_rdata,
   output logic [8:0]    row,
   output logic [8:0]    col,
   output logic          busy
);
   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_MARK, S_MOVE} state_t;
   typedef enum logic [1:0] {D_RIGHT, D_UP, D_DOWN} dir_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(HSIZE * VSIZE - 1);
   localparam logic [8:0]    COL_MAX   = 9'(HSIZE - 1);
   localparam logic [8:0]    ROW_MAX   = 9'(VSIZE - 1);
   localparam logic [3:0]    STEP_CNT  = 4'(STEP);

   state_t        r_state, w_state_next;
   dir_t          r_dir, w_dir_next;
   logic [8:0]    r_row, w_row_next;
   logic [8:0]    r_col, w_col_next;
   logic [AW-1:0] r_clr_addr, w_clr_addr_next;
   logic [3:0]    r_cnt, w_cnt_next;
   logic [2:0]    r_btn_prev;
   logic          r_disp_valid;
`ifndef CURSOR_TRAIL_EN
   logic          r_phase, w_phase_next;
`endif

   logic [2:0]    w_edge;
   logic [8:0]    w_step_row, w_step_col;
   logic [AW-1:0] w_cur_addr, w_step_addr, w_wr_addr;
   logic          w_wr_pend, w_wr_data, w_grant;

   assign w_edge = PushButton & ~r_btn_prev;

   // Coordinate one step ahead in the latched direction, with wrap-around.
   always_comb begin
      w_step_row = r_row;
      w_step_col = r_col;
      case (r_dir)
         D_RIGHT: w_step_col = (r_col == COL_MAX) ? 9'd0 : r_col + 9'd1;
         D_UP:    w_step_row = (r_row == ROW_MAX) ? 9'd0 : r_row + 9'd1;
         D_DOWN:  w_step_row = (r_row == 9'd0) ? ROW_MAX : r_row - 9'd1;
         default: ;
      endcase
   end

   assign w_cur_addr  = AW'(r_row) * AW'(HSIZE) + AW'(r_col);
   assign w_step_addr = AW'(w_step_row) * AW'(HSIZE) + AW'(w_step_col);

   // Internal write the current state wants to issue.
   always_comb begin
      w_wr_pend = 1'b0;
      w_wr_addr = '0;
      w_wr_data = 1'b0;
      case (r_state)
         S_CLEAR: begin
            w_wr_pend = 1'b1;
            w_wr_addr = r_clr_addr;
         end
         S_MARK: begin
            w_wr_pend = 1'b1;
            w_wr_addr = w_cur_addr;
            w_wr_data = 1'b1;
         end
         S_MOVE: begin
            w_wr_pend = 1'b1;
`ifdef CURSOR_TRAIL_EN
            w_wr_addr = w_step_addr;
            w_wr_data = 1'b1;
`else
            w_wr_addr = r_phase ? w_step_addr : w_cur_addr;
            w_wr_data = r_phase;
`endif
         end
         default: ;
      endcase
   end

   assign w_grant = w_wr_pend & ~disp_req & ~RESET;

   always_comb begin
      w_state_next    = r_state;
      w_dir_next      = r_dir;
      w_row_next      = r_row;
      w_col_next      = r_col;
      w_clr_addr_next = r_clr_addr;
      w_cnt_next      = r_cnt;
`ifndef CURSOR_TRAIL_EN
      w_phase_next    = r_phase;
`endif
      case (r_state)
         S_IDLE: begin
            if (clr_req) begin
               w_state_next    = S_CLEAR;
               w_clr_addr_next = '0;
            end else if (w_edge != 3'b000) begin
               w_state_next = S_MOVE;
               w_cnt_next   = STEP_CNT;
`ifndef CURSOR_TRAIL_EN
               w_phase_next = 1'b0;
`endif
               if (w_edge[0])      w_dir_next = D_RIGHT;
               else if (w_edge[1]) w_dir_next = D_UP;
               else                w_dir_next = D_DOWN;
            end
         end
         S_CLEAR: begin
            if (w_grant) begin
               if (r_clr_addr == LAST_ADDR) w_state_next = S_MARK;
               else                         w_clr_addr_next = r_clr_addr + 1'b1;
            end
         end
         S_MARK: begin
            if (w_grant) w_state_next = S_IDLE;
         end
         S_MOVE: begin
`ifdef CURSOR_TRAIL_EN
            if (w_grant) begin
`else
            if (w_grant && !r_phase) w_phase_next = 1'b1;
            if (w_grant && r_phase) begin
               w_phase_next = 1'b0;
`endif
               w_row_next = w_step_row;
               w_col_next = w_step_col;
               w_cnt_next = r_cnt - 4'd1;
               if (r_cnt == 4'd1) w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state      <= S_CLEAR;
         r_dir        <= D_RIGHT;
         r_row        <= 9'd0;
         r_col        <= 9'd0;
         r_clr_addr   <= '0;
         r_cnt        <= 4'd0;
         r_btn_prev   <= 3'b000;
         r_disp_valid <= 1'b0;
`ifndef CURSOR_TRAIL_EN
         r_phase      <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_next;
         r_dir        <= w_dir_next;
         r_row        <= w_row_next;
         r_col        <= w_col_next;
         r_clr_addr   <= w_clr_addr_next;
         r_cnt        <= w_cnt_next;
         r_btn_prev   <= PushButton;
         r_disp_valid <= disp_req;
`ifndef CURSOR_TRAIL_EN
         r_phase      <= w_phase_next;
`endif
      end
   end

   assign disp_data  = mem_rdata;
   assign disp_valid = r_disp_valid;
   assign mem_en     = ~RESET & (disp_req | w_wr_pend);
   assign mem_we     = w_grant;
   assign mem_addr   = disp_req ? disp_addr : w_wr_addr;
   assign mem_wdata  = w_grant & w_wr_data;
   assign row        = r_row;
   assign col        = r_col;
   assign busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_cursor_paint_ctrl.sv
// Self-checking bench for cursor_paint_ctrl on a reduced 20x12 bitmap, with a behavioural RAM and write scoreboard.
module tb_cursor_paint_ctrl;
   localparam int HS   = 20;
   localparam int VS   = 12;
   localparam int ST   = 5;
   localparam int AW   = 8;
   localparam int NPIX = HS * VS;
`ifdef CURSOR_TRAIL_EN
   localparam int WPS  = 1;
`else
   localparam int WPS  = 2;
`endif
   localparam int NW   = ST * WPS;

   logic          clk = 1'b0;
   logic          RESET;
   logic [2:0]    PushButton;
   logic          clr_req, disp_req;
   logic [AW-1:0] disp_addr;
   logic          disp_data, disp_valid, mem_en, mem_we, mem_wdata;
   logic          mem_rdata = 1'b0;
   logic [AW-1:0] mem_addr;
   logic [8:0]    row, col;
   logic          busy;

   cursor_paint_ctrl #(.HSIZE(HS), .VSIZE(VS), .STEP(ST), .AW(AW)) dut (
      .CLK(clk), .RESET(RESET), .PushButton(PushButton), .clr_req(clr_req),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
      .disp_valid(disp_valid), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .row(row), .col(col), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; int data; } wr_t;
   wr_t  exp_q[$];
   wr_t  popped;
   bit   exp_bmp [NPIX];
   int   m_row, m_col;
   int   errors = 0, checks = 0;
   int   dv_cnt = 0;
   bit   exp_dv = 1'b0;
   logic ram [0:(1<<AW)-1];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push_wr(input int a, input int d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
      exp_bmp[a] = (d != 0);
   endtask

   task automatic model_clear();
      for (int a = 0; a < NPIX; a++) push_wr(a, 0);
      push_wr(m_row * HS + m_col, 1);
   endtask

   // d: 0 right, 1 up, 2 down
   task automatic model_move(input int d);
      for (int s = 0; s < ST; s++) begin
         int nr, nc;
         nr = m_row;
         nc = m_col;
         if (d == 0)      nc = (m_col + 1) % HS;
         else if (d == 1) nr = (m_row + 1) % VS;
         else             nr = (m_row + VS - 1) % VS;
`ifndef CURSOR_TRAIL_EN
         push_wr(m_row * HS + m_col, 0);
`endif
         push_wr(nr * HS + nc, 1);
         m_row = nr;
         m_col = nc;
      end
   endtask

   // RAM model: synchronous, one-cycle read latency
   always @(posedge clk) begin
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
      exp_dv <= disp_req && !RESET;
   end

   always @(negedge clk) begin
      chk("disp_valid", int'(disp_valid), int'(exp_dv));
      if (disp_valid) begin
         dv_cnt++;
         chk("disp_data", int'(disp_data), int'(mem_rdata));
      end
      if (disp_req) begin
         chk("disp_grant", int'({mem_en, mem_we}), 2);
         chk("disp_addr", int'(mem_addr), int'(disp_addr));
      end else begin
         chk("stray_read", int'(mem_en && !mem_we), 0);
      end
      if (RESET) chk("reset_en", int'(mem_en), 0);
      if (mem_en && mem_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", int'(mem_addr), -1);
         end else begin
            popped = exp_q.pop_front();
            chk("wr_addr", int'(mem_addr), popped.addr);
            chk("wr_data", int'(mem_wdata), popped.data);
         end
      end
   end

   task automatic wait_idle(output int n);
      n = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
   endtask

   task automatic finish_op(input string nm, input int er, input int ec, input int ecyc);
      int n;
      wait_idle(n);
      $display("%s: busy_cycles=%0d row=%0d col=%0d", nm, n, row, col);
      chk({nm, "_cycles"}, n, ecyc);
      chk({nm, "_row"}, int'(row), er);
      chk({nm, "_col"}, int'(col), ec);
      chk({nm, "_q_empty"}, exp_q.size(), 0);
      PushButton = 3'b000;
   endtask

   task automatic press(input logic [2:0] b);
      model_move(b[0] ? 0 : (b[1] ? 1 : 2));
      @(posedge clk);
      #1 PushButton = b;
   endtask

   initial begin
      int diffs, lit;
      RESET = 1'b1; PushButton = 3'b000; clr_req = 1'b0; disp_req = 1'b0; disp_addr = '0;
      m_row = 0; m_col = 0;
      repeat (2) @(posedge clk);
      #1 model_clear(); RESET = 1'b0;
      // abort the clear part-way and restart it
      repeat (50) @(posedge clk);
      #1 RESET = 1'b1;
      @(posedge clk);
      #1 exp_q.delete(); m_row = 0; m_col = 0; model_clear(); RESET = 1'b0;
      finish_op("reset_clear", 0, 0, NPIX + 1);

      // down from row 0 wraps to VS-1; first lit write at 11*20+0
      press(3'b100);
      chk("model_down_first", exp_q[WPS-1].addr, 220);
      @(posedge clk);
      finish_op("down", 7, 0, NW);

      press(3'b001);
      @(posedge clk);
      finish_op("right", 7, 5, NW);

      // right+up together: right wins; a fresh up edge mid-move is dropped
      press(3'b011);
      fork
         begin
            @(posedge clk);
            finish_op("right_up", 7, 10, NW);
         end
         begin
            @(posedge clk);
            #1 PushButton = 3'b001;
            @(posedge clk);
            #1 PushButton = 3'b011;
         end
      join

      // display holds the port 10 cycles in the middle of a move
      dv_cnt = 0;
      press(3'b100);
      fork
         begin
            @(posedge clk);
            finish_op("down_stall", 2, 10, NW + 10);
         end
         begin
            @(posedge clk);
            @(posedge clk);
            #1;
            for (int i = 0; i < 10; i++) begin
               disp_addr = AW'(i * 23);
               disp_req  = 1'b1;
               @(posedge clk);
               #1;
            end
            disp_req = 1'b0;
         end
      join
      chk("stall_disp_valid_cnt", dv_cnt, 10);

      model_clear();
      chk("model_mark_addr", exp_q[NPIX].addr, 50);
      @(posedge clk);
      #1 clr_req = 1'b1;
      @(posedge clk);
      #1 clr_req = 1'b0;
      finish_op("clr_req", 2, 10, NPIX + 1);

      press(3'b001);
      @(posedge clk);
      finish_op("right2", 2, 15, NW);
      press(3'b001);
      @(posedge clk);
      finish_op("right_wrap", 2, 0, NW);
      press(3'b010);
      @(posedge clk);
      finish_op("up", 7, 0, NW);

      diffs = 0;
      lit = 0;
      for (int a = 0; a < NPIX; a++) begin
         if (ram[a] !== exp_bmp[a]) diffs++;
         if (ram[a] === 1'b1) lit++;
      end
      $display("bitmap: diffs=%0d lit=%0d", diffs, lit);
      chk("bitmap_diffs", diffs, 0);
      chk("cursor_lit", int'(ram[7 * HS + 0]), 1);
`ifndef CURSOR_TRAIL_EN
      chk("single_lit", lit, 1);
`else
      chk("trail_lit", lit, 1 + 5 + 5 + 5);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
